// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl: owns the register-file write port; zero-sweeps after reset, then merges pipeline and host writes
module regfile_wr_ctrl #(
    parameter int DWIDTH       = 32,
    parameter int NUM_THREADS  = 4,
    parameter int REGFILE_SIZE = 32,
    parameter int ENABLE_INIT  = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(NUM_THREADS)-1:0] i_thread_index_writeback,
    input  logic [4:0]                     i_write_addr,
    input  logic [DWIDTH-1:0]              i_write_data,
    input  logic                           i_wr_en,
    input  logic                           i_host_valid,
    output logic                           o_host_ready,
    input  logic [$clog2(NUM_THREADS)-1:0] i_host_thread,
    input  logic [4:0]                     i_host_addr,
    input  logic [DWIDTH-1:0]              i_host_data,
    output logic                           o_rf_wr_en,
    output logic [$clog2(NUM_THREADS)-1:0] o_rf_wr_thread,
    output logic [4:0]                     o_rf_wr_addr,
    output logic [DWIDTH-1:0]              o_rf_wr_data,
    output logic                           o_init_done
);
    localparam int TW = $clog2(NUM_THREADS);
    localparam int AW = $clog2(REGFILE_SIZE);
    localparam int CW = $clog2(REGFILE_SIZE * NUM_THREADS);
    localparam logic [CW-1:0] LAST = CW'(REGFILE_SIZE * NUM_THREADS - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [TW-1:0]     thr_q, thr_d;
    logic [4:0]        addr_q, addr_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              pipe_wr, host_hs;

    // x0 pipeline writes are dropped here so they never steal the slot from the host
    assign pipe_wr      = i_wr_en && (i_write_addr != 5'd0);
    assign o_host_ready = !reset && (state_q == RUN) && !pipe_wr;
    assign host_hs      = i_host_valid && o_host_ready;

    // Next-state: sweep counter during INIT, pipe-over-host arbitration during RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en_d = 1'b0;
        thr_d   = thr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = done_q;
        if (state_q == INIT) begin
            wr_en_d = 1'b1;
            thr_d   = cnt_q[CW-1:AW];
            addr_d  = 5'(cnt_q[AW-1:0]);
            data_d  = '0;
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == LAST) ? RUN : INIT;
            done_d  = (cnt_q == LAST);
        end else begin
            done_d = 1'b1;
            if (pipe_wr) begin
                wr_en_d = 1'b1;
                thr_d   = i_thread_index_writeback;
                addr_d  = i_write_addr;
                data_d  = i_write_data;
            end else if (host_hs) begin
                wr_en_d = (i_host_addr != 5'd0);
                thr_d   = i_host_thread;
                addr_d  = i_host_addr;
                data_d  = i_host_data;
            end
        end
    end

    // State and registered write-port outputs; reset restarts the sweep from entry 0
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= (ENABLE_INIT != 0) ? INIT : RUN;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            thr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            thr_q   <= thr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign o_rf_wr_en     = wr_en_q;
    assign o_rf_wr_thread = thr_q;
    assign o_rf_wr_addr   = addr_q;
    assign o_rf_wr_data   = data_q;
    assign o_init_done    = done_q;
endmodule
